// File: rtl/fxp_alu_scheduler_if.sv
// Request, response and shared-ALU signals of the two-requester fixed-point ALU scheduler.
// The scheduler connects through the slave modport; requesters and the ALU use master.
interface fxp_alu_scheduler_if #(
  parameter int N = 32
);
  logic         req0_valid;
  logic         req0_ready;
  logic [N-1:0] req0_a;
  logic [N-1:0] req0_b;
  logic [1:0]   req0_op;
  logic         req1_valid;
  logic         req1_ready;
  logic [N-1:0] req1_a;
  logic [N-1:0] req1_b;
  logic [1:0]   req1_op;

  logic         rsp0_valid;
  logic         rsp0_ready;
  logic [N-1:0] rsp0_data;
  logic         rsp0_err;
  logic         rsp1_valid;
  logic         rsp1_ready;
  logic [N-1:0] rsp1_data;
  logic         rsp1_err;

  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [1:0]   alu_op;
  logic         alu_start;
  logic [N-1:0] alu_out;
  logic         busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_op, alu_start,
    input  alu_out,
    output busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_op, alu_start,
    output alu_out,
    input  busy
  );
endinterface

// File: rtl/fxp_alu_scheduler.sv
// Round-robin arbiter that shares one signed-magnitude fixed-point ALU between two
// requesters, one transaction at a time, with divide wait and divide-by-zero handling.
module fxp_alu_scheduler #(
  parameter int N        = 32,
  parameter int Q        = 12,
  parameter int DIV_WAIT = N + Q + 1
) (
  input  logic i_clk,
  input  logic i_rst,
  fxp_alu_scheduler_if.slave bus
);
  localparam int            CW       = $clog2(DIV_WAIT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(DIV_WAIT);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [1:0]    OP_DIV   = 2'b11;

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_EXEC,
    ST_DWAIT,
    ST_RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ptr_q, ptr_d;
  logic          id_q, id_d;
  logic [N-1:0]  alu_a_q, alu_a_d;
  logic [N-1:0]  alu_b_q, alu_b_d;
  logic [1:0]    alu_op_q, alu_op_d;
  logic          alu_start_q, alu_start_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [N-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;

  logic          idle;
  logic          grant0, grant1;
  logic [N-1:0]  sel_a, sel_b;
  logic [1:0]    sel_op;
  logic          sel_rsp_ready;
  logic          b_zero;

  // When both requesters are valid the pointer breaks the tie.
  assign idle          = (state_q == ST_IDLE);
  assign grant0        = bus.req0_valid && (!bus.req1_valid || !ptr_q);
  assign grant1        = bus.req1_valid && (!bus.req0_valid ||  ptr_q);
  assign sel_a         = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b         = grant1 ? bus.req1_b  : bus.req0_b;
  assign sel_op        = grant1 ? bus.req1_op : bus.req0_op;
  assign sel_rsp_ready = id_q ? bus.rsp1_ready : bus.rsp0_ready;
  assign b_zero        = (alu_b_q[N-2:0] == '0);

  assign bus.req0_ready = idle && grant0;
  assign bus.req1_ready = idle && grant1;
  assign bus.rsp0_valid = rsp_valid_q && !id_q;
  assign bus.rsp1_valid = rsp_valid_q &&  id_q;
  assign bus.rsp0_data  = rsp_data_q;
  assign bus.rsp1_data  = rsp_data_q;
  assign bus.rsp0_err   = rsp_err_q;
  assign bus.rsp1_err   = rsp_err_q;
  assign bus.alu_a      = alu_a_q;
  assign bus.alu_b      = alu_b_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.alu_start  = alu_start_q;
  assign bus.busy       = !idle;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    id_d        = id_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_op_d    = alu_op_q;
    alu_start_d = 1'b0;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      // Drains any divide the ALU may still be running from before reset.
      ST_FLUSH: begin
        if (cnt_q <= CNT_ONE) state_d = ST_IDLE;
        else                  cnt_d   = cnt_q - CNT_ONE;
      end
      ST_IDLE: begin
        if (grant0 || grant1) begin
          id_d        = grant1;
          ptr_d       = !grant1;
          alu_a_d     = sel_a;
          alu_b_d     = sel_b;
          alu_op_d    = sel_op;
          alu_start_d = (sel_op == OP_DIV) && (sel_b[N-2:0] != '0);
          state_d     = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (alu_op_q != OP_DIV) begin
          rsp_data_d  = bus.alu_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else if (b_zero) begin
          rsp_data_d  = {alu_a_q[N-1] ^ alu_b_q[N-1], {(N-1){1'b1}}};
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d   = CNT_INIT;
          state_d = ST_DWAIT;
        end
      end
      ST_DWAIT: begin
        if (cnt_q <= CNT_ONE) begin
          rsp_data_d  = bus.alu_out;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_RESP: begin
        if (sel_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_FLUSH;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= CNT_INIT;
      ptr_q       <= 1'b0;
      id_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= '0;
      alu_start_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ptr_q       <= ptr_d;
      id_q        <= id_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_op_q    <= alu_op_d;
      alu_start_q <= alu_start_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end
endmodule

// File: tb/tb_fxp_alu_scheduler.sv
// Bench for fxp_alu_scheduler: a fixed-point ALU stand-in, a timestamp-based transaction
// model compared every cycle, and directed transactions with hand-computed results.
module tb_fxp_alu_scheduler;
  localparam int N = 32;
  localparam int Q = 12;
  localparam int DIV_WAIT = 45;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  int errors = 0;
  int checks = 0;
  int cycleNo = 0;
  int startCount = 0;
  int divCnt = 0;

  fxp_alu_scheduler_if #(.N(N)) bus();

  fxp_alu_scheduler #(.N(N), .Q(Q), .DIV_WAIT(DIV_WAIT)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cycleNo <= cycleNo + 1;

  // Signed-magnitude Q12 arithmetic done with ordinary signed integers.
  function automatic logic [N-1:0] fxpCalc(input logic [1:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
    longint ma, mb, va, vb, r, mr;
    logic s;
    ma = longint'(a[N-2:0]);
    mb = longint'(b[N-2:0]);
    va = a[N-1] ? -ma : ma;
    vb = b[N-1] ? -mb : mb;
    r  = 0;
    mr = 0;
    s  = 1'b0;
    case (op)
      OP_ADD: r = va + vb;
      OP_SUB: r = va - vb;
      OP_MUL: begin s = a[N-1] ^ b[N-1]; mr = (ma * mb) >> Q; end
      default: begin s = a[N-1] ^ b[N-1]; mr = (mb != 0) ? ((ma << Q) / mb) : 0; end
    endcase
    if (op == OP_ADD || op == OP_SUB) begin
      s  = (r < 0);
      mr = s ? -r : r;
    end
    return {s, mr[N-2:0]};
  endfunction

  // The ALU stand-in shows garbage until a divide has had its full settling time.
  always @(posedge i_clk) begin
    if (bus.alu_start === 1'b1) divCnt <= DIV_WAIT - 1;
    else if (divCnt > 0)        divCnt <= divCnt - 1;
  end
  assign bus.alu_out = (bus.alu_op == OP_DIV && divCnt != 0) ? 32'hDEADBEEF
                                                             : fxpCalc(bus.alu_op, bus.alu_a, bus.alu_b);

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycleNo);
    end
  endtask

  // Transaction model: each accepted request has an accept cycle and a response cycle.
  bit mStarted = 1'b0;
  bit mInflight = 1'b0;
  bit mId = 1'b0;
  bit mPtr = 1'b0;
  int mFlushEnd = 0, mAcc = 0, mRsp = 0, mStart = -1;
  logic [N-1:0] mA, mB, mData;
  logic [1:0] mOp;
  logic mErr;
  bit inFlush, isIdle, g0, g1, expV0, expV1, divz;

  always @(negedge i_clk) begin
    if (bus.alu_start === 1'b1) startCount++;
    if (mStarted) begin
      inFlush = (cycleNo < mFlushEnd);
      isIdle  = !inFlush && !mInflight;
      g0 = bus.req0_valid && (!bus.req1_valid || !mPtr);
      g1 = bus.req1_valid && (!bus.req0_valid ||  mPtr);
      expV0 = mInflight && (cycleNo >= mRsp) && !mId;
      expV1 = mInflight && (cycleNo >= mRsp) &&  mId;
      checkVal("req0_ready", bus.req0_ready, isIdle && g0);
      checkVal("req1_ready", bus.req1_ready, isIdle && g1);
      checkVal("busy", bus.busy, !isIdle);
      checkVal("rsp0_valid", bus.rsp0_valid, expV0);
      checkVal("rsp1_valid", bus.rsp1_valid, expV1);
      checkVal("alu_start", bus.alu_start, mInflight && (cycleNo == mStart));
      if (expV0) begin
        checkVal("rsp0_data", bus.rsp0_data, mData);
        checkVal("rsp0_err", bus.rsp0_err, mErr);
      end
      if (expV1) begin
        checkVal("rsp1_data", bus.rsp1_data, mData);
        checkVal("rsp1_err", bus.rsp1_err, mErr);
      end
      if (mInflight && cycleNo > mAcc && cycleNo < mRsp) begin
        checkVal("alu_a", bus.alu_a, mA);
        checkVal("alu_b", bus.alu_b, mB);
        checkVal("alu_op", bus.alu_op, mOp);
      end
    end
    if (i_rst) begin
      mStarted  = 1'b1;
      mFlushEnd = cycleNo + 1 + DIV_WAIT;
      mInflight = 1'b0;
      mPtr      = 1'b0;
    end else if (mStarted) begin
      if (isIdle && (g0 || g1)) begin
        mInflight = 1'b1;
        mId   = g1;
        mPtr  = !g1;
        mAcc  = cycleNo;
        mA    = g1 ? bus.req1_a  : bus.req0_a;
        mB    = g1 ? bus.req1_b  : bus.req0_b;
        mOp   = g1 ? bus.req1_op : bus.req0_op;
        divz  = (mOp == OP_DIV) && (mB[N-2:0] == '0);
        mErr  = divz;
        mData = divz ? {mA[N-1] ^ mB[N-1], {(N-1){1'b1}}} : fxpCalc(mOp, mA, mB);
        if (mOp == OP_DIV && !divz) begin
          mRsp   = cycleNo + 2 + DIV_WAIT;
          mStart = cycleNo + 1;
        end else begin
          mRsp   = cycleNo + 2;
          mStart = -1;
        end
      end else if (mInflight && cycleNo >= mRsp && (mId ? bus.rsp1_ready : bus.rsp0_ready)) begin
        mInflight = 1'b0;
      end
    end
  end

  task automatic setReq(input int k, input logic v, input logic [1:0] op, input logic [N-1:0] a,
                        input logic [N-1:0] b);
    if (k == 0) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
    end
  endtask

  task automatic setRspReady(input int k, input logic v);
    if (k == 0) bus.rsp0_ready = v;
    else        bus.rsp1_ready = v;
  endtask

  function automatic logic getReady(input int k);
    return (k == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic getRspValid(input int k);
    return (k == 0) ? bus.rsp0_valid : bus.rsp1_valid;
  endfunction

  function automatic logic [N-1:0] getRspData(input int k);
    return (k == 0) ? bus.rsp0_data : bus.rsp1_data;
  endfunction

  function automatic logic getRspErr(input int k);
    return (k == 0) ? bus.rsp0_err : bus.rsp1_err;
  endfunction

  // One complete request/response on requester k; expWait < 0 skips the wait-length check.
  task automatic applyStimulus(input int k, input logic [1:0] op, input logic [N-1:0] a,
                               input logic [N-1:0] b, input logic [N-1:0] expData,
                               input logic expErr, input int expLat, input int expWait,
                               input int hold, input string tag, output int accCycle);
    int waitCnt;
    int lat;
    bit got;
    waitCnt  = 0;
    lat      = 0;
    got      = 1'b0;
    accCycle = -1;
    setReq(k, 1'b1, op, a, b);
    setRspReady(k, hold == 0);
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge i_clk);
      if (getReady(k)) got = 1'b1;
      else             waitCnt++;
    end
    if (!got) begin
      checkVal({tag, " accept timeout"}, 32'd0, 32'd1);
      setReq(k, 1'b0, op, a, b);
      setRspReady(k, 1'b1);
      return;
    end
    accCycle = cycleNo;
    @(posedge i_clk);
    #1;
    setReq(k, 1'b0, op, a, b);
    if (expWait >= 0) checkVal({tag, " wait cycles"}, waitCnt, expWait);
    got = 1'b0;
    for (int i = 1; i <= 100 && !got; i++) begin
      @(negedge i_clk);
      if (getRspValid(k)) begin
        got = 1'b1;
        lat = i;
      end
    end
    if (!got) begin
      checkVal({tag, " response timeout"}, 32'd0, 32'd1);
      setRspReady(k, 1'b1);
      return;
    end
    checkOutput(k, tag, lat, expLat, expData, expErr);
    if (hold > 0) begin
      repeat (hold) @(posedge i_clk);
      #1;
      setRspReady(k, 1'b1);
    end
    @(posedge i_clk);
    #1;
  endtask

  task automatic checkOutput(input int k, input string tag, input int lat, input int expLat,
                             input logic [N-1:0] expData, input logic expErr);
    checkVal({tag, " latency"}, lat, expLat);
    checkVal({tag, " data"}, getRspData(k), expData);
    checkVal({tag, " err"}, getRspErr(k), expErr);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc0, acc1, s0;
    bit got;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    setReq(0, 1'b0, OP_ADD, '0, '0);
    setReq(1, 1'b0, OP_ADD, '0, '0);

    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkVal("reset busy", bus.busy, 1'b1);
    checkVal("reset rsp0_data", bus.rsp0_data, 32'h0);
    checkVal("reset rsp1_data", bus.rsp1_data, 32'h0);
    checkVal("reset rsp0_err", bus.rsp0_err, 1'b0);
    checkVal("reset alu_a", bus.alu_a, 32'h0);
    checkVal("reset alu_b", bus.alu_b, 32'h0);
    checkVal("reset alu_op", bus.alu_op, 2'b00);
    checkVal("reset alu_start", bus.alu_start, 1'b0);

    applyStimulus(0, OP_ADD, 32'h00001000, 32'h00002000, 32'h00003000, 1'b0, 2, 45, 0,
                  "add0 after flush", acc0);
    applyStimulus(1, OP_SUB, 32'h00001000, 32'h00003000, 32'h80002000, 1'b0, 2, 0, 0,
                  "sub1", acc1);

    fork
      applyStimulus(0, OP_MUL, 32'h00002000, 32'h00003000, 32'h00006000, 1'b0, 2, -1, 0,
                    "mul0 pair", acc0);
      applyStimulus(1, OP_MUL, 32'h80001800, 32'h00002000, 32'h80003000, 1'b0, 2, -1, 0,
                    "mul1 pair", acc1);
    join
    checkVal("pair1 req0 served first", acc0 < acc1, 1'b1);

    applyStimulus(0, OP_ADD, 32'h00000800, 32'h80001800, 32'h80001000, 1'b0, 2, 0, 0,
                  "add0 mixed sign", acc0);

    s0 = startCount;
    fork
      applyStimulus(1, OP_DIV, 32'h00006000, 32'h00002000, 32'h00003000, 1'b0, 47, -1, 0,
                    "div1 6/2", acc1);
      applyStimulus(0, OP_ADD, 32'h00004000, 32'h00000001, 32'h00004001, 1'b0, 2, -1, 0,
                    "add0 stalled", acc0);
    join
    checkVal("pair2 req1 served first", acc1 < acc0, 1'b1);
    checkVal("req0 stall length", acc0 - acc1, 32'd48);
    checkVal("div alu_start pulses", startCount - s0, 32'd1);

    s0 = startCount;
    applyStimulus(0, OP_DIV, 32'h80001000, 32'h00000000, 32'hFFFFFFFF, 1'b1, 2, 0, 0,
                  "div0 by zero", acc0);
    checkVal("div by zero alu_start pulses", startCount - s0, 32'd0);

    fork
      applyStimulus(0, OP_ADD, 32'h00001234, 32'h00001000, 32'h00002234, 1'b0, 2, 0, 10,
                    "held rsp0", acc0);
      begin
        @(posedge i_clk);
        #2;
        setReq(1, 1'b1, OP_MUL, 32'h00004000, 32'h00004000);
      end
    join
    applyStimulus(1, OP_MUL, 32'h00004000, 32'h00004000, 32'h00010000, 1'b0, 2, 0, 0,
                  "mul1 after hold", acc1);
    checkVal("req1 accept after held rsp0", acc1 - acc0, 32'd13);

    setReq(1, 1'b1, OP_DIV, 32'h00009000, 32'h00003000);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge i_clk);
      if (bus.req1_ready) got = 1'b1;
    end
    checkVal("abort div accepted", got, 1'b1);
    @(posedge i_clk);
    #1;
    setReq(1, 1'b0, OP_DIV, 32'h00009000, 32'h00003000);
    repeat (26) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    checkVal("abort busy", bus.busy, 1'b1);
    checkVal("abort rsp1_valid", bus.rsp1_valid, 1'b0);
    applyStimulus(0, OP_DIV, 32'h00009000, 32'h00003000, 32'h00003000, 1'b0, 47, 45, 0,
                  "div after abort", acc0);

    repeat (3) @(posedge i_clk);
    $display("[TB] Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fxp_alu_scheduler.md
FXP_ALU_SCHEDULER -- requirements
Module: fxp_alu_scheduler

Interface
REQ-001 Parameter N, default 32: operand/result width, signed-magnitude fixed point, bit N-1 = sign.
REQ-002 Parameter Q, default 12: fractional bits.
REQ-003 Parameter DIV_WAIT, default 45 (N+Q+1): cycles from the shared ALU sampling alu_start to a stable divide result.
REQ-004 Port i_clk, input, 1: the single clock; all logic on its rising edge.
REQ-005 Port i_rst, input, 1: reset, synchronous, active-high.
REQ-006 Ports reqK_valid, input, 1 (K=0,1): requester K has an operation pending.
REQ-007 Ports reqK_ready, output, 1: request accepted when reqK_valid && reqK_ready at a rising edge.
REQ-008 Ports reqK_a / reqK_b, input, N: operands.
REQ-009 Ports reqK_op, input, 2: 00 add, 01 sub, 10 mul, 11 div.
REQ-010 Ports rspK_valid, output, 1; rspK_ready, input, 1: response handshake.
REQ-011 Ports rspK_data, output, N; rspK_err, output, 1: result and divide-by-zero flag.
REQ-012 Ports alu_a / alu_b, output, N; alu_op, output, 2; alu_start, output, 1: drive the shared fixed-point ALU.
REQ-013 Port alu_out, input, N: ALU result.
REQ-014 Port busy, output, 1: high in every state except IDLE.

Function
REQ-015 FSM states: FLUSH, IDLE, EXEC, DWAIT, RESP; one transaction outstanding at a time.
REQ-016 reqK_ready = (state==IDLE) && grant==K, computed combinationally from reqK_valid and the priority pointer; at most one ready high.
REQ-017 Round-robin: if only one requester is valid, grant it; if both are valid, grant the requester named by the pointer; after each accept, the pointer points to the other requester.
REQ-018 On accept in cycle C: latch a, b, op and requester id; alu_a/alu_b/alu_op are registered and driven from cycle C+1 until the response is captured.
REQ-019 add/sub/mul: EXEC in C+1; capture alu_out at the end of C+1; RESP, rspK_valid=1 from C+2.
REQ-020 div with b[N-2:0]!=0: alu_start=1 for exactly cycle C+1, then DWAIT with counter=DIV_WAIT; capture alu_out when the counter reaches 0; rspK_valid from cycle C+2+DIV_WAIT.
REQ-021 div with b[N-2:0]==0: alu_start is never asserted; rspK_data={a[N-1]^b[N-1], all ones}, rspK_err=1, rspK_valid from C+2.
REQ-022 rspK_err=0 for every other result.
REQ-023 alu_start is asserted only for div; all other states drive it 0.
REQ-024 RESP: rspK_valid and rspK_data are held stable until rspK_ready; transition to IDLE at the end of the handshake cycle; the other requester's rsp_valid stays 0.
REQ-025 A request arriving while busy waits with ready low; requests are never dropped.
REQ-026 rspK_ready asserted while rspK_valid=0 is ignored.
REQ-027 The response is routed only to the requester whose request was accepted, independent of the current pointer value.

Reset
REQ-028 While i_rst=1 at an edge: state<=FLUSH, counter<=DIV_WAIT, pointer<=0, alu_a/alu_b/alu_op<=0, alu_start<=0, rspK_valid<=0, rspK_data<=0, rspK_err<=0.
REQ-029 FLUSH holds reqK_ready=0 and busy=1 for DIV_WAIT cycles after reset deasserts, then enters IDLE; this drains an ALU divide left running across reset.
REQ-030 Reset asserted mid-transaction discards that transaction; no response is ever issued for it.

Verification
REQ-031 After reset, req0 add 0x00001000+0x00002000 -> ready low for 45 cycles; then rsp0_data=0x00003000, err=0, valid 2 cycles after accept.
REQ-032 req0 and req1 both valid with mul requests, pointer=0 -> req0 served first, then req1; next simultaneous pair -> req1 served first.
REQ-033 req1 div 0x00006000 / 0x00002000 (6.0/2.0) -> alu_start single pulse; rsp1_data=0x00003000 exactly 47 cycles after accept; req0 stalled throughout.
REQ-034 req0 div 0x80001000 / 0x00000000 -> rsp0_data=0xFFFFFFFF, rsp0_err=1, alu_start never asserted.
REQ-035 rsp0_ready held low for 10 cycles -> rsp0_valid and rsp0_data stable; req1 not accepted until the cycle after the rsp0 handshake.
REQ-036 i_rst pulsed at DWAIT count 20 -> no response; FLUSH 45 cycles; a following div returns the correct quotient.
